// File: rtl/or_seq_pkg.sv
// Shared types and bus address map for the A|B OR datapath sequencer.
package or_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_A,
    WR_A,
    CHK_B,
    WR_B,
    POLL_Y,
    RD_Y,
    OUT
  } state_e;

  localparam int ADDR_A_STAT = 0;
  localparam int ADDR_B_STAT = 1;
  localparam int ADDR_Y_STAT = 2;
  localparam int ADDR_Y_DATA = 3;
  localparam int ADDR_A_DATA = 4;
  localparam int ADDR_B_DATA = 5;

endpackage

// File: rtl/or_seq_poll_timer.sv
// Counts consecutive POLL_Y cycles; expired marks the LIMIT-th cycle.
module or_seq_poll_timer #(
  parameter int LIMIT = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Any cycle outside POLL_Y clears the count, so every poll phase starts at zero.
  always_ff @(posedge CLK) begin
    if (RST || !run) count <= '0;
    else             count <= count + 1'b1;
  end

  assign expired = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/or_seq_ctrl.sv
// Bus-master sequencer: writes A then B, polls Y, pops Y onto the result stream.
// Optional poll timeout enabled by defining OR_SEQ_TIMEOUT_EN.
module or_seq_ctrl
  import or_seq_pkg::*;
#(
  parameter int DW             = 8,
  parameter int AW             = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [AW-1:0] write_address,
  output logic [DW-1:0] write_data,
  output logic          write_en,
  input  logic          write_rdy,
  output logic [AW-1:0] read_address,
  output logic          read_en,
  input  logic [DW-1:0] read_data,
  input  logic          read_rdy,
  output logic          busy,
  output logic          err,
  input  logic          err_clr,
  output logic [15:0]   res_count
);

  state_e        state;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic          timeout_hit;

`ifdef OR_SEQ_TIMEOUT_EN
  or_seq_poll_timer #(.LIMIT(TIMEOUT_CYCLES)) u_poll_timer (
    .CLK     (CLK),
    .RST     (RST),
    .run     (state == POLL_Y),
    .expired (timeout_hit)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  // NOTE: the stream-side ready is decoded from state but masked by RST so no
  // pair can be accepted during the reset cycle itself.
  assign op_ready = (state == IDLE) && !RST;
  assign busy     = (state != IDLE);

  // NOTE: every register here uses non-blocking assignment; later assignments in
  // the same cycle override earlier ones, which gives timeout priority over err_clr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_count     <= '0;
      write_address <= '0;
      write_data    <= '0;
      write_en      <= 1'b0;
      read_address  <= '0;
      read_en       <= 1'b0;
`ifdef OR_SEQ_TIMEOUT_EN
      err           <= 1'b0;
`endif
    end else begin
`ifdef OR_SEQ_TIMEOUT_EN
      if (err_clr) err <= 1'b0;
`endif
      case (state)
        IDLE: if (op_valid) begin
          a_reg        <= op_a;
          b_reg        <= op_b;
          read_address <= AW'(ADDR_A_STAT);
          state        <= CHK_A;
        end
        CHK_A: if (read_rdy && read_data[0]) begin
          write_address <= AW'(ADDR_A_DATA);
          write_data    <= a_reg;
          write_en      <= 1'b1;
          state         <= WR_A;
        end
        WR_A: if (write_rdy) begin
          write_address <= '0;
          write_data    <= '0;
          write_en      <= 1'b0;
          read_address  <= AW'(ADDR_B_STAT);
          state         <= CHK_B;
        end
        CHK_B: if (read_rdy && read_data[0]) begin
          write_address <= AW'(ADDR_B_DATA);
          write_data    <= b_reg;
          write_en      <= 1'b1;
          state         <= WR_B;
        end
        WR_B: if (write_rdy) begin
          write_address <= '0;
          write_data    <= '0;
          write_en      <= 1'b0;
          read_address  <= AW'(ADDR_Y_STAT);
          state         <= POLL_Y;
        end
        // Status polls never strobe read_en; only the Y data read pops.
        POLL_Y: begin
          if (read_rdy && read_data[0]) begin
            read_address <= AW'(ADDR_Y_DATA);
            read_en      <= 1'b1;
            state        <= RD_Y;
          end else if (timeout_hit) begin
            read_address <= '0;
            state        <= IDLE;
`ifdef OR_SEQ_TIMEOUT_EN
            err          <= 1'b1;
`endif
          end
        end
        RD_Y: if (read_rdy) begin
          res_data     <= read_data;
          res_valid    <= 1'b1;
          read_address <= '0;
          read_en      <= 1'b0;
          state        <= OUT;
        end
        OUT: if (res_ready) begin
          res_valid <= 1'b0;
          res_count <= res_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_seq_ctrl.sv
// Directed bench for or_seq_ctrl with a small register-mapped OR datapath model.
module tb_or_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
`ifdef OR_SEQ_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 1023;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          write_rdy = 1'b1;
  logic [AW-1:0] read_address;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          read_rdy = 1'b1;
  logic          busy;
  logic          err;
  logic          err_clr = 1'b0;
  logic [15:0]   res_count;

  logic          a_stat = 1'b1;
  logic          b_stat = 1'b1;
  logic          y_stat = 1'b1;
  logic [DW-1:0] a_w = '0;
  logic [DW-1:0] b_w = '0;
  int writes_a = 0, writes_b = 0, pops = 0, bad_reads = 0;
  int checks = 0, failures = 0;

  or_seq_ctrl #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy),
    .busy(busy), .err(err), .err_clr(err_clr), .res_count(res_count)
  );

  always #5 CLK = ~CLK;

  // Datapath model: status bits from bench flags, Y = last A | last B.
  always_comb begin
    read_data = '0;
    case (read_address)
      3'd0:    read_data = DW'(a_stat);
      3'd1:    read_data = DW'(b_stat);
      3'd2:    read_data = DW'(y_stat);
      3'd3:    read_data = a_w | b_w;
      default: read_data = '0;
    endcase
  end

  always @(posedge CLK) begin
    if (write_en && write_rdy) begin
      if (write_address == 3'd4) begin a_w <= write_data; writes_a++; end
      if (write_address == 3'd5) begin b_w <= write_data; writes_b++; end
    end
    if (read_en && read_rdy) begin
      if (read_address == 3'd3) pops++;
      else                      bad_reads++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    check("accept_ready", op_ready, 1'b1);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, res_valid, 1'b1);
  endtask

  task automatic wait_poll(input string tag);
    int n = 0;
    while (!(busy && read_address == 3'd2 && !write_en) && n < 40) begin
      step();
      n++;
    end
    check(tag, read_address, 3'd2);
  endtask

  initial begin
    int n;
    int wb0;
    int pops0;

    // Reset state
    step();
    step();
    check("rst_op_ready", op_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_write_en", write_en, 1'b0);
    check("rst_read_en", read_en, 1'b0);
    check("rst_res_count", res_count, 16'd0);
    check("rst_err", err, 1'b0);
    RST = 1'b0;
    step();
    check("idle_op_ready", op_ready, 1'b1);

    // Basic pair with idle bus: result in cycle 7
    start_op(8'h0F, 8'hF0);
    check("op_ready_low_busy", op_ready, 1'b0);
    wait_res("t1_res_valid", n);
    check("t1_latency", n + 1, 7);
    check("t1_res_data", res_data, 8'hFF);
    check("t1_a_written", a_w, 8'h0F);
    check("t1_b_written", b_w, 8'hF0);
    check("t1_writes_a", writes_a, 1);
    check("t1_writes_b", writes_b, 1);
    check("t1_pops", pops, 1);
    step();
    check("t1_res_count", res_count, 16'd1);
    check("t1_back_idle", op_ready, 1'b1);

    // A FIFO full for 5 cycles
    a_stat = 1'b0;
    start_op(8'h33, 8'h44);
    for (int i = 0; i < 5; i++) begin
      check("t2_no_write", write_en, 1'b0);
      check("t2_busy", busy, 1'b1);
      step();
    end
    a_stat = 1'b1;
    step();
    check("t2_write_en", write_en, 1'b1);
    check("t2_write_addr", write_address, 3'd4);
    check("t2_write_data", write_data, 8'h33);
    wait_res("t2_res_valid", n);
    check("t2_res_data", res_data, 8'h77);
    step();
    check("t2_res_count", res_count, 16'd2);

    // write_rdy stalls WR_B for 3 cycles
    wb0 = writes_b;
    start_op(8'h12, 8'h21);
    n = 0;
    while (!(write_en && write_address == 3'd5) && n < 20) begin
      step();
      n++;
    end
    write_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_en", write_en, 1'b1);
      check("t3_hold_addr", write_address, 3'd5);
      check("t3_hold_data", write_data, 8'h21);
    end
    write_rdy = 1'b1;
    step();
    check("t3_write_done", write_en, 1'b0);
    check("t3_single_write", writes_b - wb0, 1);
    wait_res("t3_res_valid", n);
    check("t3_res_data", res_data, 8'h33);
    step();
    check("t3_res_count", res_count, 16'd3);

    // Result back-pressure
    res_ready = 1'b0;
    start_op(8'hA5, 8'h0A);
    wait_res("t4_res_valid", n);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_hold_valid", res_valid, 1'b1);
      check("t4_hold_data", res_data, 8'hAF);
      check("t4_op_ready", op_ready, 1'b0);
      check("t4_count_hold", res_count, 16'd3);
    end
    res_ready = 1'b1;
    step();
    check("t4_res_count", res_count, 16'd4);
    check("t4_res_valid_low", res_valid, 1'b0);
    check("t4_op_ready", op_ready, 1'b1);

    // Reset while polling Y
    y_stat = 1'b0;
    start_op(8'h01, 8'h02);
    wait_poll("t5_reach_poll");
    step();
    step();
    check("t5_still_busy", busy, 1'b1);
    RST = 1'b1;
    step();
    check("t5_busy", busy, 1'b0);
    check("t5_read_en", read_en, 1'b0);
    check("t5_write_en", write_en, 1'b0);
    check("t5_res_count", res_count, 16'd0);
    check("t5_op_ready_rst", op_ready, 1'b0);
    RST = 1'b0;
    step();
    check("t5_op_ready", op_ready, 1'b1);

    // Y never ready
    pops0 = pops;
    start_op(8'h04, 8'h08);
    wait_poll("t6_reach_poll");
`ifdef OR_SEQ_TIMEOUT_EN
    n = 1;
    while (busy && n < 50) begin
      step();
      if (busy) n++;
    end
    check("t6_poll_cycles", n, 10);
    check("t6_err", err, 1'b1);
    check("t6_no_pop", pops - pops0, 0);
    check("t6_res_count", res_count, 16'd0);
    check("t6_res_valid", res_valid, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t6_err_clr", err, 1'b0);
`else
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("t6_err_tied", err, 1'b0);
    check("t6_waiting", busy, 1'b1);
    check("t6_no_pop", pops - pops0, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    check("t6_idle", busy, 1'b0);
`endif
    y_stat = 1'b1;
    check("no_stray_reads", bad_reads, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/or_seq_ctrl.md
Name: or_seq_ctrl

Overview:
- Bus-master sequencer for the register-mapped A|B OR datapath (A operand FIFO, B operand FIFO, Y result FIFO behind one 3-bit write/read address bus).
- Accepts operand pairs on a valid/ready stream, writes A then B after checking FIFO space, polls for Y, pops Y and presents it on a result stream.
- Sits between a stream producer/consumer and the datapath; it is the sole owner of the datapath bus.

Parameters:
- DW, 8, operand/result/bus data width.
- AW, 3, bus address width.
- TIMEOUT_CYCLES, 1023, POLL_Y cycles before abort (used only with the optional feature).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted when op_valid & op_ready.
- op_a  in  DW  A operand.
- op_b  in  DW  B operand.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_data  out  DW  result (A|B as returned by datapath).
- write_address  out  AW  bus write address.
- write_data  out  DW  bus write data.
- write_en  out  1  bus write strobe.
- write_rdy  in  1  bus write ready; write completes when write_en & write_rdy.
- read_address  out  AW  bus read address.
- read_en  out  1  bus read strobe (pops at addr 3 only).
- read_data  in  DW  bus read data, combinational on read_address.
- read_rdy  in  1  bus read ready.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag (0 without optional feature).
- err_clr  in  1  clears err.
- res_count  out  16  results delivered, wraps at 0xFFFF->0.

Behaviour:
- Reset: state IDLE; op_ready, res_valid, write_en, read_en, busy, err = 0; res_data, res_count, write/read address/data = 0; operand regs 0. op_ready forced 0 while RST high.
- Bus outputs decoded from registered state/operands only; no combinational path from read_data or write_rdy to bus outputs.
- Status polls use read_en = 0 (read_en at addr 0 would pop A); read_data sampled only when read_rdy = 1.
- States and transitions:
  - IDLE: op_ready = 1; on op_valid capture op_a/op_b -> CHK_A.
  - CHK_A: read_address = 0; read_rdy & read_data[0] -> WR_A; else stay.
  - WR_A: write_address = 4, write_data = A, write_en = 1; write_rdy -> CHK_B; else hold all bus values.
  - CHK_B: read_address = 1; read_rdy & read_data[0] -> WR_B.
  - WR_B: write_address = 5, write_data = B, write_en = 1; write_rdy -> POLL_Y.
  - POLL_Y: read_address = 2, read_en = 0; read_rdy & read_data[0] -> RD_Y.
  - RD_Y: read_address = 3, read_en = 1; read_rdy -> capture read_data into res_data -> OUT. Exactly one pop per operand pair.
  - OUT: res_valid = 1, res_data stable; res_ready -> res_count += 1 -> IDLE.
- Latency: idle bus with space and immediate Y: accept in cycle 0, res_valid in cycle 7. Datapath compute gating may stretch POLL_Y arbitrarily.
- No pipelining: one pair in flight; op_ready = 0 outside IDLE.
- res_ready held high in OUT: back-to-back accept earliest the following cycle (IDLE).
- RST mid-operation: immediate return to IDLE, strobes drop the next cycle. Partially written operands are not recovered; the datapath is reset alongside.
- err_clr and a timeout in the same cycle: err = 1 (set wins).

Optional Feature:
- Macro OR_SEQ_TIMEOUT_EN.
- With: poll counter clears on POLL_Y entry and increments each POLL_Y cycle. On reaching TIMEOUT_CYCLES without Y, set err, skip RD_Y/OUT, return to IDLE; res_count unchanged.
- Without: POLL_Y waits indefinitely; err tied 0; err_clr ignored.

Decomposition:
- Package or_seq_pkg:
  - state enum (IDLE, CHK_A, WR_A, CHK_B, WR_B, POLL_Y, RD_Y, OUT).
  - Address constants: ADDR_A_STAT = 0, ADDR_B_STAT = 1, ADDR_Y_STAT = 2, ADDR_Y_DATA = 3, ADDR_A_DATA = 4, ADDR_B_DATA = 5.
- One sub-module, or_seq_poll_timer (timeout counter), instantiated only under OR_SEQ_TIMEOUT_EN.

Test Plan:
- Reset then op_a = 0x0F, op_b = 0xF0, bus always ready, Y ready on first poll -> writes addr 4 = 0x0F then addr 5 = 0xF0; res_valid in cycle 7 with res_data = 0xFF; res_count = 1.
- A status reads 0 for 5 cycles -> stays CHK_A, write_en = 0 throughout; write to addr 4 issued the cycle after status reads 1.
- write_rdy low 3 cycles in WR_B -> write_address = 5 and write_data held stable, single completed write, no duplicate.
- res_ready low 4 cycles in OUT -> res_valid and res_data stable, op_ready = 0; count increments once on handshake.
- RST asserted while in POLL_Y -> next cycle IDLE, busy = 0, read_en = 0, res_count = 0.
- OR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 10, Y never ready -> err = 1 after 10 POLL_Y cycles, no addr 3 read; err_clr pulse -> err = 0.
